// File: rtl/logic_gate_unit.sv
// logic_gate_unit
//   Registered two-operand bitwise logic unit. Each transaction selects one
//   of eight gate functions (AND, OR, NOT A, NOR, NAND, XOR, XNOR, NOT B)
//   through a 3-bit opcode. Results are queued in a 2-entry output buffer
//   with valid/ready handshakes on both sides. A saturating counter records
//   the number of accepted operations.
//
//   Optional feature macro: LGU_REDUCE_EN
//     When defined, the outputs red_and / red_or / red_xor are added. They
//     carry the AND, OR and XOR reductions of the head result. These bits are
//     computed at push time and buffered alongside each entry.
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [2:0]       out_op,
  output logic [CNT_W-1:0] op_count
`ifdef LGU_REDUCE_EN
  ,
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor
`endif
);

  // Opcode encoding
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOTA = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_NOTB = 3'd7;

  // Buffer occupancy values
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------
  // Function datapath
  // Every opcode is expressed as a 2-input truth table indexed by
  // {a_bit, b_bit}. The same 4-bit table is then applied to every bit
  // lane, which is exactly a row of single-bit gates.
  // ---------------------------------------------------------------------
  logic [3:0]       truth_table;
  logic [WIDTH-1:0] result;

  // Select the truth table for the requested function
  always_comb begin
    truth_table = 4'b0000;
    case (in_op)
      OP_AND:  truth_table = 4'b1000;
      OP_OR:   truth_table = 4'b1110;
      OP_NOTA: truth_table = 4'b0011;
      OP_NOR:  truth_table = 4'b0001;
      OP_NAND: truth_table = 4'b0111;
      OP_XOR:  truth_table = 4'b0110;
      OP_XNOR: truth_table = 4'b1001;
      OP_NOTB: truth_table = 4'b0101;
      default: truth_table = 4'b0000;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_lane
      // Each lane is independent: no carry or cross-bit interaction
      assign result[gi] = truth_table[{in_a[gi], in_b[gi]}];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Handshake and occupancy control
  // ---------------------------------------------------------------------
  logic [1:0] count_reg;
  logic [1:0] count_next;
  logic       out_valid_reg;
  logic       push;
  logic       pop;
  logic       head_load;
  logic       head_from_tail;
  logic       tail_load;

  // Ready comes only from the occupancy register and reset. out_ready is
  // deliberately not used, so no combinational ready path exists.
  assign in_ready = (count_reg < OCC_FULL) & ~rst;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid_reg & out_ready;

  // Decide how the head/tail slots move for this cycle's push/pop mix
  always_comb begin
    count_next     = count_reg;
    head_load      = 1'b0;
    head_from_tail = 1'b0;
    tail_load      = 1'b0;
    case ({push, pop})
      2'b10: begin
        count_next = count_reg + 2'd1;
        if (count_reg == OCC_EMPTY) begin
          head_load = 1'b1;
        end else begin
          tail_load = 1'b1;
        end
      end
      2'b01: begin
        count_next = count_reg - 2'd1;
        // When the only entry leaves, the head is left as-is so out_y
        // keeps showing the last result while the buffer is empty.
        if (count_reg == OCC_FULL) begin
          head_from_tail = 1'b1;
        end
      end
      2'b11: begin
        // A push requires count<2 and a pop requires count>0, so both
        // together means exactly one entry. The new result replaces it.
        head_load = 1'b1;
      end
      default: begin
        count_next = count_reg;
      end
    endcase
  end

  // Occupancy and registered out_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg     <= OCC_EMPTY;
      out_valid_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      out_valid_reg <= (count_next != OCC_EMPTY);
    end
  end

  // ---------------------------------------------------------------------
  // Buffer storage: head slot drives the outputs, tail slot queues behind
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] head_y_reg;
  logic [2:0]       head_op_reg;
  logic [WIDTH-1:0] tail_y_reg;
  logic [2:0]       tail_op_reg;

  // Head entry: loaded from the datapath or promoted from the tail
  always_ff @(posedge clk) begin
    if (rst) begin
      head_y_reg  <= '0;
      head_op_reg <= '0;
    end else if (head_load) begin
      head_y_reg  <= result;
      head_op_reg <= in_op;
    end else if (head_from_tail) begin
      head_y_reg  <= tail_y_reg;
      head_op_reg <= tail_op_reg;
    end
  end

  // Tail entry: only written when a push lands behind an occupied head
  always_ff @(posedge clk) begin
    if (rst) begin
      tail_y_reg  <= '0;
      tail_op_reg <= '0;
    end else if (tail_load) begin
      tail_y_reg  <= result;
      tail_op_reg <= in_op;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_y     = head_y_reg;
  assign out_op    = head_op_reg;

`ifdef LGU_REDUCE_EN
  // ---------------------------------------------------------------------
  // Reduction flags, computed at push and carried with each entry
  // ---------------------------------------------------------------------
  logic [2:0] red_new;
  logic [2:0] head_red_reg;
  logic [2:0] tail_red_reg;

  assign red_new = {^result, |result, &result};

  // Reduction bits follow the same head/tail movement as the data
  always_ff @(posedge clk) begin
    if (rst) begin
      head_red_reg <= 3'b000;
      tail_red_reg <= 3'b000;
    end else begin
      if (head_load) begin
        head_red_reg <= red_new;
      end else if (head_from_tail) begin
        head_red_reg <= tail_red_reg;
      end
      if (tail_load) begin
        tail_red_reg <= red_new;
      end
    end
  end

  assign red_and = head_red_reg[0];
  assign red_or  = head_red_reg[1];
  assign red_xor = head_red_reg[2];
`endif

  // ---------------------------------------------------------------------
  // Accepted-operation counter, saturating at its maximum value
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] op_count_reg;

  // Count every accept, holding at the maximum instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_reg <= '0;
    end else if (push && (op_count_reg != CNT_MAX)) begin
      op_count_reg <= op_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign op_count = op_count_reg;

endmodule

// File: tb/tb_logic_gate_unit.sv
// tb_logic_gate_unit
//   Self-checking bench for logic_gate_unit (WIDTH=8, CNT_W=4). A monitor
//   keeps a scoreboard: expected {op, y} entries are pushed when an accept
//   is seen and popped/compared when the consumer takes the head. Each
//   scenario task also checks handshake timing, counters and reset inline.
module tb_logic_gate_unit;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [2:0]       out_op;
  logic [CNT_W-1:0] op_count;
`ifdef LGU_REDUCE_EN
  logic             red_and;
  logic             red_or;
  logic             red_xor;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [10:0] sb[$];

  logic_gate_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_op    (out_op),
    .op_count  (op_count)
`ifdef LGU_REDUCE_EN
    ,
    .red_and   (red_and),
    .red_or    (red_or),
    .red_xor   (red_xor)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return ~(a | b);
      3'd4: return ~(a & b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return ~b;
    endcase
  endfunction

  // Scoreboard monitor: sample handshakes mid-cycle, away from the edge
  always @(negedge clk) begin
    logic [10:0] e;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: got op=%0d y=0x%02h, required no output", out_op, out_y);
        end else begin
          e = sb.pop_front();
          if ({out_op, out_y} !== e) begin
            $display("FAIL sb_data: got op=%0d y=0x%02h, required op=%0d y=0x%02h",
                     out_op, out_y, e[10:8], e[7:0]);
          end else begin
            pass_cnt++;
          end
`ifdef LGU_REDUCE_EN
          chk_cnt++;
          if ({red_xor, red_or, red_and} !== {^e[7:0], |e[7:0], &e[7:0]}) begin
            $display("FAIL sb_reduce: got %b%b%b, required %b%b%b", red_xor, red_or, red_and,
                     ^e[7:0], |e[7:0], &e[7:0]);
          end else begin
            pass_cnt++;
          end
`endif
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back({in_op, model(in_a, in_b, in_op)});
        $display("accept op=%0d a=0x%02h b=0x%02h", in_op, in_a, in_b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;
    step(); step();
    chk_cnt++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b, required 0", in_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({out_valid, out_y, out_op, op_count} !== '0)
      $display("FAIL reset_state: got v=%b y=0x%02h op=%0d cnt=%0d, required all 0",
               out_valid, out_y, out_op, op_count);
    else pass_cnt++;
    rst = 1'b0;
    step();
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, required 1", in_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({out_valid, out_y, op_count} !== '0)
      $display("FAIL reset_idle: got v=%b y=0x%02h cnt=%0d, required all 0",
               out_valid, out_y, op_count);
    else pass_cnt++;
  endtask

  task automatic test_all_ops();
    logic [7:0] tbl [8];
    tbl = '{8'h42, 8'hDB, 8'h3C, 8'h24, 8'hBD, 8'h99, 8'h66, 8'hA5};
    in_a = 8'hC3; in_b = 8'h5A; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_op = 3'(i);
      step();
      chk_cnt++;
      if (out_valid !== 1'b1 || out_y !== tbl[i] || out_op !== 3'(i))
        $display("FAIL all_ops_%0d: got v=%b y=0x%02h op=%0d, required v=1 y=0x%02h op=%0d",
                 i, out_valid, out_y, out_op, tbl[i], i);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    chk_cnt++;
    if (op_count !== 4'd8) $display("FAIL all_ops_count: got %0d, required 8", op_count);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (out_valid !== 1'b0 || out_y !== 8'hA5)
      $display("FAIL empty_hold: got v=%b y=0x%02h, required v=0 y=0xa5", out_valid, out_y);
    else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd5;
    in_a = 8'h0F; in_b = 8'hFF;
    step();
    in_a = 8'h01; in_b = 8'h01;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL b2b_second_ready: got %b, required 1", in_ready);
    else pass_cnt++;
    step();
    in_a = 8'hAA; in_b = 8'h55;
    chk_cnt++;
    if (in_ready !== 1'b0 || out_y !== 8'hF0)
      $display("FAIL b2b_full: got rdy=%b y=0x%02h, required rdy=0 y=0xf0", in_ready, out_y);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_y !== 8'hF0)
      $display("FAIL b2b_hold: got rdy=%b v=%b y=0x%02h, required rdy=0 v=1 y=0xf0",
               in_ready, out_valid, out_y);
    else pass_cnt++;
    // Full buffer, consumer ready and producer offering in the same cycle
    out_ready = 1'b1;
    step();
    chk_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_y !== 8'h00)
      $display("FAIL full_pop_no_push: got rdy=%b v=%b y=0x%02h, required rdy=1 v=1 y=0x00",
               in_ready, out_valid, out_y);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b1 || out_y !== 8'hFF)
      $display("FAIL b2b_third: got v=%b y=0x%02h, required v=1 y=0xff", out_valid, out_y);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL b2b_drained: got v=%b rdy=%b, required v=0 rdy=1", out_valid, in_ready);
    else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom_range(0, 7));
      step();
    end
    chk_cnt++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL flush_prefill: got v=%b rdy=%b, required v=1 rdy=0", out_valid, in_ready);
    else pass_cnt++;
    rst = 1'b1;
    step();
    chk_cnt++;
    if ({out_valid, out_y, out_op, op_count} !== '0)
      $display("FAIL flush_state: got v=%b y=0x%02h op=%0d cnt=%0d, required all 0",
               out_valid, out_y, out_op, op_count);
    else pass_cnt++;
    rst = 1'b0; in_valid = 1'b0;
    step();
    chk_cnt++;
    if (out_valid !== 1'b0 || op_count !== 4'd0)
      $display("FAIL flush_dropped: got v=%b cnt=%0d, required v=0 cnt=0", out_valid, op_count);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    int n = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom_range(0, 7));
      step();
      n++;
      chk_cnt++;
      if (op_count !== 4'((n > 15) ? 15 : n))
        $display("FAIL sat_count_%0d: got %0d, required %0d", n, op_count, (n > 15) ? 15 : n);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
  endtask

`ifdef LGU_REDUCE_EN
  task automatic test_reduce();
    out_ready = 1'b0; in_valid = 1'b1;
    in_a = 8'h80; in_b = 8'h00; in_op = 3'd1;
    step();
    in_valid = 1'b0;
    chk_cnt++;
    if ({red_and, red_or, red_xor} !== 3'b011)
      $display("FAIL reduce_0x80: got and=%b or=%b xor=%b, required 0 1 1",
               red_and, red_or, red_xor);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask
`endif

  task automatic test_random_stream();
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom_range(0, 7));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) step();
    step();
    chk_cnt++;
    if (sb.size() != 0 || out_valid !== 1'b0)
      $display("FAIL stream_drain: got %0d pending v=%b, required 0 pending v=0",
               sb.size(), out_valid);
    else pass_cnt++;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_ops();
    test_back_to_back();
    test_reset_flush();
    test_saturation();
`ifdef LGU_REDUCE_EN
    test_reduce();
`endif
    test_random_stream();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
